// File: rtl/double_to_float.sv
// IEEE-754 binary64 -> binary32 narrowing converter with strobe/ack handshakes.
// Rounds to nearest-even (or truncates) and produces subnormal results.
module double_to_float #(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_result,
  output logic        output_result_stb,
  input  logic        output_result_ack
);

  typedef enum logic [2:0] {
    GET_A,
    UNPACK,
    DENORM,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  state_t             state;
  logic [63:0]        a;
  logic               sign;
  logic signed [11:0] ee;
  logic [23:0]        mant;
  logic               guard;
  logic               round_bit;
  logic               sticky;

  logic [10:0]        a_exp;
  logic               a_frac_zero;
  logic signed [11:0] unpack_ee;
  logic               round_up;
  logic [24:0]        round_sum;
  logic [7:0]         pack_exp;

  // The biased exponent only needs its low byte: ee is at most 127 here.
  always_comb begin
    a_exp       = a[62:52];
    a_frac_zero = (a[51:0] == 52'd0);
    unpack_ee   = $signed({1'b0, a_exp}) - 12'sd1023;
    round_up    = ROUND_EN && guard && (round_bit || sticky || mant[0]);
    round_sum   = {1'b0, mant} + 25'd1;
    pack_exp    = mant[23] ? (ee[7:0] + 8'd127) : 8'd0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= GET_A;
      input_a_ack       <= 1'b0;
      output_result     <= 32'd0;
      output_result_stb <= 1'b0;
      a                 <= 64'd0;
      sign              <= 1'b0;
      ee                <= 12'sd0;
      mant              <= 24'd0;
      guard             <= 1'b0;
      round_bit         <= 1'b0;
      sticky            <= 1'b0;
    end else begin
      case (state)
        GET_A: begin
          if (!input_a_ack) begin
            input_a_ack <= 1'b1;
          end else if (input_a_stb) begin
            a           <= input_a;
            input_a_ack <= 1'b0;
            state       <= UNPACK;
          end
        end

        // Specials, zeros and out-of-range magnitudes finish here in one step.
        UNPACK: begin
          sign <= a[63];
          if (a_exp == 11'h7FF) begin
            output_result     <= a_frac_zero ? {a[63], 8'hFF, 23'd0}
                                             : {a[63], 8'hFF, 1'b1, a[50:29]};
            output_result_stb <= 1'b1;
            state             <= PUT_Z;
          end else if (a_exp == 11'd0) begin
            output_result     <= {a[63], 31'd0};
            output_result_stb <= 1'b1;
            state             <= PUT_Z;
          end else if (unpack_ee > 12'sd127) begin
            output_result     <= {a[63], 8'hFF, 23'd0};
            output_result_stb <= 1'b1;
            state             <= PUT_Z;
          end else if (unpack_ee < -12'sd150) begin
            output_result     <= {a[63], 31'd0};
            output_result_stb <= 1'b1;
            state             <= PUT_Z;
          end else begin
            ee        <= unpack_ee;
            mant      <= {1'b1, a[51:29]};
            guard     <= a[28];
            round_bit <= a[27];
            sticky    <= |a[26:0];
            if (unpack_ee < -12'sd126) begin
              state <= DENORM;
            end else begin
              state <= ROUND;
            end
          end
        end

        DENORM: begin
          mant      <= mant >> 1;
          guard     <= mant[0];
          round_bit <= guard;
          sticky    <= sticky | round_bit;
          ee        <= ee + 12'sd1;
          if (ee == -12'sd127) begin
            state <= ROUND;
          end
        end

        // A carry out of the 24-bit significand renormalises to 1.0 x 2^(ee+1).
        ROUND: begin
          if (round_up) begin
            if (round_sum[24]) begin
              mant <= 24'h800000;
              ee   <= ee + 12'sd1;
            end else begin
              mant <= round_sum[23:0];
            end
          end
          state <= PACK;
        end

        PACK: begin
          if (ee > 12'sd127) begin
            output_result <= {sign, 8'hFF, 23'd0};
          end else begin
            output_result <= {sign, pack_exp, mant[22:0]};
          end
          output_result_stb <= 1'b1;
          state             <= PUT_Z;
        end

        PUT_Z: begin
          if (output_result_ack) begin
            output_result_stb <= 1'b0;
            state             <= GET_A;
          end
        end

        default: begin
          state <= GET_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_double_to_float.sv
// Directed bench for double_to_float: an integer-arithmetic RNE reference model
// plus hand-computed literal results, latency, handshake and reset checks.
module tb_double_to_float;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] input_a = 64'd0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] output_result;
  logic        output_result_stb;
  logic        output_result_ack = 1'b0;

  int          n_vectors = 0;
  int          n_miscompares = 0;
  logic [31:0] exp_result = 32'd0;

  double_to_float #(.ROUND_EN(1'b1)) dut (
    .clock             (clock),
    .reset             (reset),
    .input_a           (input_a),
    .input_a_stb       (input_a_stb),
    .input_a_ack       (input_a_ack),
    .output_result     (output_result),
    .output_result_stb (output_result_stb),
    .output_result_ack (output_result_ack)
  );

  always #5 clock = ~clock;

  // Reference: exact integer rounding of the 53-bit significand to float precision.
  function automatic logic [31:0] model(input logic [63:0] d);
    logic s;
    int e, ee, drop;
    longint unsigned sig, q, rem, half;
    s = d[63];
    e = int'(d[62:52]);
    if (e == 2047)
      return (d[51:0] == 52'd0) ? {s, 8'hFF, 23'd0} : {s, 8'hFF, 1'b1, d[50:29]};
    if (e == 0) return {s, 31'd0};
    ee = e - 1023;
    if (ee > 127) return {s, 8'hFF, 23'd0};
    sig  = {11'd0, 1'b1, d[51:0]};
    drop = (ee >= -126) ? 29 : 29 + (-126 - ee);
    if (drop > 62) return {s, 31'd0};
    q    = sig >> drop;
    rem  = sig - (q << drop);
    half = 64'd1 << (drop - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (ee >= -126) begin
      if (q == 64'd16777216) begin
        q  = 64'd8388608;
        ee = ee + 1;
      end
      if (ee > 127) return {s, 8'hFF, 23'd0};
      return {s, 8'(ee + 127), q[22:0]};
    end
    return {s, q[30:0]};
  endfunction

  function automatic int model_latency(input logic [63:0] d);
    int e, ee;
    e  = int'(d[62:52]);
    ee = e - 1023;
    if (e == 2047 || e == 0 || ee > 127 || ee < -150) return 1;
    return (ee < -126) ? 3 + (-126 - ee) : 3;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // While a result is offered it must match the model and stay put.
  always @(negedge clock) begin
    if (!reset && output_result_stb) begin
      check_output("mon_result", output_result, exp_result);
      check_output("mon_a_ack_low", {31'd0, input_a_ack}, 32'd0);
    end
  end

  task automatic start_conversion(input logic [63:0] d);
    int n;
    logic [63:0] junk;
    exp_result = model(d);
    n = 0;
    while (!input_a_ack && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check_output("a_ack_wait", {31'd0, input_a_ack}, 32'd1);
    input_a     = d;
    input_a_stb = 1'b1;
    @(posedge clock); #1;
    input_a_stb = 1'b0;
    junk        = {$urandom(), $urandom()};
    input_a     = junk;
    check_output("a_ack_drop", {31'd0, input_a_ack}, 32'd0);
  endtask

  task automatic wait_result(input logic [63:0] d, input logic [31:0] lit, input bit has_lit);
    int n;
    n = 1;
    while (!output_result_stb && n < 64) begin
      @(posedge clock); #1;
      if (!output_result_stb) n++;
    end
    if (!output_result_stb) n = 99;
    check_output($sformatf("latency %h", d), 32'(n), 32'(model_latency(d)));
    check_output($sformatf("model %h", d), output_result, exp_result);
    if (has_lit) check_output($sformatf("literal %h", d), output_result, lit);
  endtask

  task automatic release_result(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check_output("hold_stb", {31'd0, output_result_stb}, 32'd1);
    end
    output_result_ack = 1'b1;
    @(posedge clock); #1;
    output_result_ack = 1'b0;
    check_output("stb_drop", {31'd0, output_result_stb}, 32'd0);
    check_output("a_ack_still_low", {31'd0, input_a_ack}, 32'd0);
    @(posedge clock); #1;
    check_output("a_ack_rise", {31'd0, input_a_ack}, 32'd1);
  endtask

  task automatic apply_stimulus(input logic [63:0] d, input logic [31:0] lit,
                                input bit has_lit, input int hold);
    start_conversion(d);
    wait_result(d, lit, has_lit);
    release_result(hold);
  endtask

  task automatic reset_pulse_check();
    #2 reset = 1'b1;
    #1;
    check_output("rst_result", output_result, 32'd0);
    check_output("rst_stb", {31'd0, output_result_stb}, 32'd0);
    check_output("rst_a_ack", {31'd0, input_a_ack}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check_output("rst_a_ack_rise", {31'd0, input_a_ack}, 32'd1);
  endtask

  initial begin
    logic [63:0] r;
    logic        s;
    logic [10:0] e;

    #12;
    check_output("reset_result", output_result, 32'd0);
    check_output("reset_stb", {31'd0, output_result_stb}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_output("reset_a_ack", {31'd0, input_a_ack}, 32'd0);
    @(posedge clock); #1;
    check_output("first_a_ack", {31'd0, input_a_ack}, 32'd1);

    // Hand-computed literals pin both the model and the DUT.
    apply_stimulus(64'h3FF0000000000000, 32'h3F800000, 1'b1, 0);
    apply_stimulus(64'hC000000000000000, 32'hC0000000, 1'b1, 0);
    apply_stimulus(64'h3FF0000010000000, 32'h3F800000, 1'b1, 0);
    apply_stimulus(64'h3FF0000030000000, 32'h3F800002, 1'b1, 0);
    apply_stimulus(64'h3FEFFFFFF0000000, 32'h3F800000, 1'b1, 0);
    apply_stimulus(64'h47F0000000000000, 32'h7F800000, 1'b1, 0);
    apply_stimulus(64'hFFF0000000000000, 32'hFF800000, 1'b1, 0);
    apply_stimulus(64'h7FF8000000000000, 32'h7FC00000, 1'b1, 0);
    apply_stimulus(64'h8000000000000000, 32'h80000000, 1'b1, 0);
    apply_stimulus(64'h36A0000000000000, 32'h00000001, 1'b1, 0);
    apply_stimulus(64'h3690000000000000, 32'h00000000, 1'b1, 0);
    apply_stimulus(64'h3690000000000001, 32'h00000001, 1'b1, 0);
    apply_stimulus(64'h0000000000000001, 32'h00000000, 1'b1, 0);
    apply_stimulus(64'h400921FB54442D18, 32'h40490FDB, 1'b1, 0);
    apply_stimulus(64'h3FB999999999999A, 32'h3DCCCCCD, 1'b1, 0);
    apply_stimulus(64'h47EFFFFFE0000000, 32'h7F7FFFFF, 1'b1, 0);
    apply_stimulus(64'h47EFFFFFF0000000, 32'h7F800000, 1'b1, 0);
    apply_stimulus(64'h380FFFFFF0000000, 32'h00800000, 1'b1, 0);
    apply_stimulus(64'hC7EFFFFFE0000001, 32'hFF7FFFFF, 1'b1, 0);

    // Backpressure: result must hold for ten cycles without ack.
    apply_stimulus(64'h3FF8000000000000, 32'h3FC00000, 1'b1, 10);

    // Model-only vectors across normal, subnormal and overflow exponents.
    for (int i = 0; i < 16; i++) begin
      r = {$urandom(), $urandom()};
      s = 1'($urandom_range(0, 1));
      e = 11'($urandom_range(860, 1160));
      apply_stimulus({s, e, r[51:0]}, 32'd0, 1'b0, i % 3);
    end

    // Reset while a subnormal conversion is shifting.
    start_conversion(64'h36A0000000000000);
    repeat (5) @(posedge clock);
    #1;
    reset_pulse_check();
    apply_stimulus(64'h3FF0000000000000, 32'h3F800000, 1'b1, 0);

    // Reset while a result is being offered clears it immediately.
    start_conversion(64'h4000000000000000);
    wait_result(64'h4000000000000000, 32'h40000000, 1'b1);
    reset_pulse_check();
    apply_stimulus(64'hC000000000000000, 32'hC0000000, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
